// File: rtl/seq_pkg.sv
// Shared link constants for seq_tx and the sequence detectors.
// Both ends of the serial link import these so framing agrees.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int         SEQ_PRE_LEN  = 4;
  localparam logic [3:0] SEQ_PREAMBLE = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Word register for seq_tx: parallel load, shift left, MSB out.
// Asynchronous active-low clear.
module seq_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end else if (shift_i) begin
      q_q <= q_q << 1;
    end
  end

  assign msb_o = q_q[WIDTH-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: preamble, data MSB-first, idle gap.
// All serial outputs are registered, one bit per clock.
module seq_tx
  import seq_pkg::*;
#(
  parameter int                 WIDTH    = 8,
  parameter int                 PRE_LEN  = SEQ_PRE_LEN,
  parameter logic [PRE_LEN-1:0] PREAMBLE = SEQ_PREAMBLE,
  parameter int                 GAP_LEN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             done
);

  if (WIDTH < 1 || PRE_LEN < 1 || GAP_LEN < 1) begin : g_bad_param
    $error("seq_tx: WIDTH, PRE_LEN and GAP_LEN must be >= 1");
  end

  localparam int CMAX = max3(PRE_LEN, WIDTH, GAP_LEN);
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] PRE_LD  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LEN - 1);

  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tx_bit_q, tx_bit_d;
  logic act_q, act_d;
  logic done_q, done_d;
  logic load, shift, msb;
  logic [PRE_LEN-1:0] pre_sh;

  seq_tx_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (load),
    .shift_i(shift),
    .d_i    (in_data),
    .msb_o  (msb)
  );

  // Counter holds the index of the preamble bit now on the line.
  assign pre_sh = PREAMBLE >> (cnt_q - CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tx_bit_q <= 1'b0;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_bit_q <= tx_bit_d;
      act_q    <= act_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_bit_d = 1'b0;
    act_d    = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load     = 1'b1;
          state_d  = ST_PRE;
          cnt_d    = PRE_LD;
          tx_bit_d = PREAMBLE[PRE_LEN-1];
          act_d    = 1'b1;
        end
      end
      ST_PRE: begin
        if (abort) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else if (cnt_q != '0) begin
          cnt_d    = cnt_q - CW'(1);
          tx_bit_d = pre_sh[0];
          act_d    = 1'b1;
        end else begin
          state_d  = ST_DATA;
          cnt_d    = DATA_LD;
          tx_bit_d = msb;
          act_d    = 1'b1;
          shift    = 1'b1;
        end
      end
      ST_DATA: begin
        if (abort) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else if (cnt_q != '0) begin
          cnt_d    = cnt_q - CW'(1);
          tx_bit_d = msb;
          act_d    = 1'b1;
          shift    = 1'b1;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign tx_bit    = tx_bit_q;
  assign tx_active = act_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: framing, back-to-back, abort, async reset.
// Per-cycle vectors are {tx_bit, tx_active, done, in_ready}.
module tb_seq_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       abort;
  logic       tx_bit;
  logic       tx_active;
  logic       done;

  int n_chk;
  int n_err;

  seq_tx dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .abort    (abort),
    .tx_bit   (tx_bit),
    .tx_active(tx_active),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pattern bit 15-k is the expectation just after edge k of the watch.
  task automatic watch(input string tag, input int n,
                       input logic [15:0] bits, input logic [15:0] act,
                       input logic [15:0] dn, input logic [15:0] rdy);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_k%0d", tag, k),
            {28'd0, tx_bit, tx_active, done, in_ready},
            {28'd0, bits[15-k], act[15-k], dn[15-k], rdy[15-k]});
    end
  endtask

  localparam logic [15:0] ACT_F = 16'b1111111111110000;
  localparam logic [15:0] DN_F  = 16'b0000000000001000;
  localparam logic [15:0] RDY_F = 16'b0000000000000010;
  localparam logic [15:0] B_A5  = 16'b1011101001010000;
  localparam logic [15:0] B_3C  = 16'b1011001111000000;
  localparam logic [15:0] B_C3  = 16'b1011110000110000;

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    abort    = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("rst_vec", {28'd0, tx_bit, tx_active, done, in_ready}, 32'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_vec", {28'd0, tx_bit, tx_active, done, in_ready}, 32'h1);

    // Single frame; in_valid left high mid-frame must be ignored
    in_valid = 1'b1;
    in_data  = 8'hA5;
    watch("a5", 15, B_A5, ACT_F, DN_F, RDY_F);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("a5_noreload", {31'd0, in_ready}, 32'h1);

    // Back-to-back with in_data changed mid-frame
    in_valid = 1'b1;
    in_data  = 8'h3C;
    fork
      begin
        repeat (5) @(posedge clk);
        #2 in_data = 8'hC3;
      end
    join_none
    watch("b2b1", 15, B_3C, ACT_F, DN_F, RDY_F);
    fork
      begin
        @(posedge clk);
        #2 in_valid = 1'b0;
      end
    join_none
    watch("b2b2", 15, B_C3, ACT_F, DN_F, RDY_F);

    // Abort during the third data bit
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    fork
      begin
        @(posedge clk);
        #2 in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
      end
    join_none
    watch("abrt", 12, 16'b1011101000000000, 16'b1111111000000000,
          16'h0000, 16'b0000000001110000);

    // Async reset mid-DATA
    in_valid = 1'b1;
    in_data  = 8'hA5;
    fork
      begin
        @(posedge clk);
        #2 in_valid = 1'b0;
      end
    join_none
    watch("prst", 7, B_A5, ACT_F, DN_F, RDY_F);
    #3 rst = 1'b0;
    #1;
    check("arst_vec", {28'd0, tx_bit, tx_active, done, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    fork
      begin
        @(posedge clk);
        #2 in_valid = 1'b0;
      end
    join_none
    watch("post", 15, B_3C, ACT_F, DN_F, RDY_F);

    // Abort together with in_valid in IDLE: word accepted
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    fork
      begin
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        abort    = 1'b0;
      end
    join_none
    watch("abidle", 15, B_C3, ACT_F, DN_F, RDY_F);

    // Abort on the last data bit: no done pulse
    in_valid = 1'b1;
    in_data  = 8'hA5;
    fork
      begin
        @(posedge clk);
        #2 in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
      end
    join_none
    watch("ablast", 15, B_A5, ACT_F, 16'h0000, RDY_F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
